// File: rtl/gf163_pkg.sv
// Shared GF(2^163) constants for the reducer and the multiplier bench.
// f(x) = x^163 + x^7 + x^6 + x^3 + 1.
package gf163_pkg;
  localparam int M       = 163;
  localparam int PROD_W  = 325;
  localparam int TOP_W   = 9;
  localparam int NTAPS   = 4;
  localparam int RED_TAPS [NTAPS] = '{0, 3, 6, 7};

  typedef enum logic [1:0] {S_IDLE, S_FOLD, S_DONE} state_e;

  // Fold cycles needed to sweep bits 324..163 in windows of 'digit' bits.
  function automatic int nfold(input int digit);
    return (PROD_W - M + digit - 1) / digit;
  endfunction
endpackage

// File: rtl/gf163_fold_step.sv
// One window fold: clears acc[top : max(top-DIGIT+1,163)] and XORs each
// cleared bit back in at the reduction taps below x^163's shadow.
module gf163_fold_step
  import gf163_pkg::*;
#(
  parameter int DIGIT = 18
) (
  input  logic [PROD_W-1:0] acc_i,
  input  logic [TOP_W-1:0]  top_i,
  output logic [PROD_W-1:0] acc_o
);

  // Targets land at i-156 or lower, always below the window, so the clear
  // and the tap XORs can share one pass.
  always_comb begin
    int lo;
    lo = int'(top_i) - DIGIT + 1;
    if (lo < M) lo = M;
    acc_o = acc_i;
    for (int i = M; i < PROD_W; i++) begin
      if (i >= lo && i <= int'(top_i)) begin
        acc_o[i] = 1'b0;
        for (int t = 0; t < NTAPS; t++)
          acc_o[i-M+RED_TAPS[t]] = acc_o[i-M+RED_TAPS[t]] ^ acc_i[i];
      end
    end
  end

endmodule

// File: rtl/gf163_reduce_seq.sv
// Digit-serial reducer: 325-bit carry-less product -> GF(2^163) element.
// Constant latency regardless of operand value.
module gf163_reduce_seq
  import gf163_pkg::*;
#(
  parameter int DIGIT = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [M-1:0]      out_elem
);

  localparam int               NFOLD     = nfold(DIGIT);
  localparam logic [TOP_W-1:0] TOP_START = TOP_W'(PROD_W - 1);
  localparam logic [TOP_W-1:0] DIG_STEP  = TOP_W'(DIGIT);
  localparam logic [7:0]       LAST      = 8'(NFOLD - 1);

  if (DIGIT < 1 || DIGIT > 156) begin : g_bad_digit
    $error("gf163_reduce_seq: DIGIT must be within 1..156");
  end

  state_e            state_q;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [TOP_W-1:0]  top_q;
  logic [7:0]        cnt_q;
  logic              in_ready_q, out_valid_q;

  gf163_fold_step #(.DIGIT(DIGIT)) u_fold (
    .acc_i (acc_q),
    .top_i (top_q),
    .acc_o (acc_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      top_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            acc_q      <= in_prod;
            top_q      <= TOP_START;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_FOLD;
          end
        end
        S_FOLD: begin
          acc_q <= acc_d;
          top_q <= top_q - DIG_STEP;
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == LAST) begin
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_elem  = acc_q[M-1:0];

endmodule
